bip_control_unit: RTL and testbench

Multi-cycle control unit of the BIP accumulator processor. It fetches 16-bit instructions, decodes the 5-bit opcode, and sequences the datapath. It drives the accumulator-input select of `Multiplexor_3in_1out` (0 = data memory, 1 = sign-extended immediate, 2 = ALU result), the ALU operand/operation controls, the data-RAM strobes and the program counter. It sits between the instruction ROM, the data RAM and the accumulator datapath.

---
 rtl/bip_pkg.sv | 25 ++
 rtl/bip_control_unit_if.sv | 43 ++++
 rtl/bip_program_counter.sv | 20 ++
 rtl/bip_control_unit.sv | 120 ++++++++++++
 tb/tb_bip_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states and
// accumulator-mux select encodings.
package bip_pkg;

   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   localparam logic [1:0] SEL_RAM = 2'd0;
   localparam logic [1:0] SEL_IMM = 2'd1;
   localparam logic [1:0] SEL_ALU = 2'd2;

endpackage

// File: rtl/bip_control_unit_if.sv
// Control bus between the BIP control unit, instruction ROM, data RAM and
// accumulator datapath. InstrCount exists only with BIP_CTRL_INSTR_COUNT_EN.
interface bip_control_unit_if
   import bip_pkg::*;
#(
   parameter int PC_WIDTH   = 11,
   parameter int OPND_WIDTH = 11
);
   // Run is a level qualifier, not a valid/ready pair: it is sampled only in
   // FETCH, and an instruction once fetched always completes.
   logic                  Run;
   logic [15:0]           Instr;
   logic [PC_WIDTH-1:0]   PcAddr;
   logic [OPND_WIDTH-1:0] Operand;
   logic [1:0]            SelA;
   logic                  SelB;
   logic                  Op;
   logic                  WrAcc;
   logic                  RdRam;
   logic                  WrRam;
   logic                  Halted;
   state_t                state;
`ifdef BIP_CTRL_INSTR_COUNT_EN
   logic [15:0]           InstrCount;
`endif

   modport master (
      input  Run, Instr,
      output PcAddr, Operand, SelA, SelB, Op, WrAcc, RdRam, WrRam, Halted, state
`ifdef BIP_CTRL_INSTR_COUNT_EN
      , output InstrCount
`endif
   );

   modport slave (
      output Run, Instr,
      input  PcAddr, Operand, SelA, SelB, Op, WrAcc, RdRam, WrRam, Halted, state
`ifdef BIP_CTRL_INSTR_COUNT_EN
      , input InstrCount
`endif
   );

endinterface

// File: rtl/bip_program_counter.sv
// Program counter: asynchronous reset to 0, +1 when inc is high, wraps at
// 2^PC_WIDTH.
module bip_program_counter #(
   parameter int PC_WIDTH = 11
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                inc,
   output logic [PC_WIDTH-1:0] pc
);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pc <= '0;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer of the BIP accumulator processor.
// Optional instruction counter enabled by defining BIP_CTRL_INSTR_COUNT_EN.
module bip_control_unit
   import bip_pkg::*;
#(
   parameter int PC_WIDTH   = 11,
   parameter int OPND_WIDTH = 11
) (
   input logic                Clock,
   input logic                Reset,
   bip_control_unit_if.master bus
);

   state_t              state, state_next;
   logic [15:0]         ir;
   logic [4:0]          opcode;
   logic [1:0]          sel_a_q, sel_a_x;
   logic                sel_b_q, sel_b_x;
   logic                op_q, op_x;
   logic                wr_acc, rd_ram, wr_ram;
   logic [PC_WIDTH-1:0] pc;

   assign opcode = ir[15:11];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= ST_FETCH;
         ir      <= '0;
         sel_a_q <= SEL_RAM;
         sel_b_q <= 1'b0;
         op_q    <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_FETCH && bus.Run) begin
            ir <= bus.Instr;
         end
         if (state == ST_EXEC) begin
            sel_a_q <= sel_a_x;
            sel_b_q <= sel_b_x;
            op_q    <= op_x;
         end
      end
   end

   // Outside EXEC the selects fall through from the held registers, so the
   // mux settings of the last executed instruction stay visible.
   always_comb begin
      state_next = state;
      sel_a_x    = sel_a_q;
      sel_b_x    = sel_b_q;
      op_x       = op_q;
      wr_acc     = 1'b0;
      rd_ram     = 1'b0;
      wr_ram     = 1'b0;
      case (state)
         ST_FETCH: begin
            if (bus.Run) state_next = ST_DECODE;
         end
         ST_DECODE: begin
            state_next = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
            rd_ram     = opcode inside {OP_LD, OP_ADD, OP_SUB};
            wr_ram     = (opcode == OP_STO);
         end
         ST_EXEC: begin
            state_next = ST_FETCH;
            case (opcode)
               OP_LD:   begin sel_a_x = SEL_RAM; wr_acc = 1'b1; end
               OP_LDI:  begin sel_a_x = SEL_IMM; wr_acc = 1'b1; end
               OP_ADD:  begin sel_a_x = SEL_ALU; sel_b_x = 1'b0; op_x = 1'b0; wr_acc = 1'b1; end
               OP_ADDI: begin sel_a_x = SEL_ALU; sel_b_x = 1'b1; op_x = 1'b0; wr_acc = 1'b1; end
               OP_SUB:  begin sel_a_x = SEL_ALU; sel_b_x = 1'b0; op_x = 1'b1; wr_acc = 1'b1; end
               OP_SUBI: begin sel_a_x = SEL_ALU; sel_b_x = 1'b1; op_x = 1'b1; wr_acc = 1'b1; end
               default: ;
            endcase
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   bip_program_counter #(
      .PC_WIDTH(PC_WIDTH)
   ) u_pc (
      .Clock(Clock),
      .Reset(Reset),
      .inc  (state == ST_EXEC),
      .pc   (pc)
   );

   assign bus.PcAddr  = pc;
   assign bus.Operand = ir[OPND_WIDTH-1:0];
   assign bus.SelA    = sel_a_x;
   assign bus.SelB    = sel_b_x;
   assign bus.Op      = op_x;
   assign bus.WrAcc   = wr_acc;
   assign bus.RdRam   = rd_ram;
   assign bus.WrRam   = wr_ram;
   assign bus.Halted  = (state == ST_HALT);
   assign bus.state   = state;

`ifdef BIP_CTRL_INSTR_COUNT_EN
   logic [15:0] instr_count;

   // Counts completed EXECs plus the single entry into HALT.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         instr_count <= '0;
      end else if (state == ST_EXEC || (state == ST_DECODE && opcode == OP_HLT)) begin
         instr_count <= instr_count + 1'b1;
      end
   end

   assign bus.InstrCount = instr_count;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: instruction-level reference model
// builds per-cycle expectations, randomized Run and programs.
module tb_bip_control_unit;

`ifdef BIP_CTRL_INSTR_COUNT_EN
   localparam int W = 46;
`else
   localparam int W = 30;
`endif

   localparam logic [4:0] T_HLT = 5'd0, T_STO = 5'd1, T_LD = 5'd2, T_LDI = 5'd3;
   localparam logic [4:0] T_ADD = 5'd4, T_ADDI = 5'd5, T_SUB = 5'd6, T_SUBI = 5'd7;

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   bip_control_unit_if #(.PC_WIDTH(11), .OPND_WIDTH(11)) bus();

   bip_control_unit #(.PC_WIDTH(11), .OPND_WIDTH(11)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clock = ~Clock;

   logic [15:0] rom [0:2047];
   assign bus.Instr = rom[bus.PcAddr];

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic         run_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic [10:0] m_pc, m_opnd;
   logic [1:0]  m_sela;
   logic        m_selb, m_op, m_halted;
   logic [15:0] m_count;

   function automatic logic [W-1:0] vec(input logic [10:0] pc, input logic [10:0] opnd,
                                        input logic [1:0] sa, input logic sb, input logic op,
                                        input logic wa, input logic rr, input logic wr,
                                        input logic h);
`ifdef BIP_CTRL_INSTR_COUNT_EN
      return {pc, opnd, sa, sb, op, wa, rr, wr, h, m_count};
`else
      return {pc, opnd, sa, sb, op, wa, rr, wr, h};
`endif
   endfunction

   function automatic logic [W-1:0] pack_dut();
`ifdef BIP_CTRL_INSTR_COUNT_EN
      return {bus.PcAddr, bus.Operand, bus.SelA, bus.SelB, bus.Op, bus.WrAcc,
              bus.RdRam, bus.WrRam, bus.Halted, bus.InstrCount};
`else
      return {bus.PcAddr, bus.Operand, bus.SelA, bus.SelB, bus.Op, bus.WrAcc,
              bus.RdRam, bus.WrRam, bus.Halted};
`endif
   endfunction

   task automatic model_reset();
      m_pc = '0; m_opnd = '0; m_sela = 2'd0; m_selb = 1'b0; m_op = 1'b0;
      m_halted = 1'b0; m_count = '0;
      exp_q.delete(); got_q.delete(); run_q.delete();
   endtask

   task automatic push(input logic [W-1:0] v, input logic r);
      exp_q.push_back(v);
      run_q.push_back(r);
   endtask

   // Cycles spent waiting in FETCH with Run low
   task automatic model_idle(input int n);
      repeat (n) push(vec(m_pc, m_opnd, m_sela, m_selb, m_op, 0, 0, 0, 0), 1'b0);
   endtask

   task automatic model_halt(input int n);
      repeat (n) push(vec(m_pc, m_opnd, m_sela, m_selb, m_op, 0, 0, 0, 1), 1'b1);
   endtask

   // One whole instruction from rom[m_pc]; Run is random after the fetch
   task automatic model_instr();
      logic [15:0] w;
      logic [4:0]  opc;
      logic        wa;
      w   = rom[m_pc];
      opc = w[15:11];
      push(vec(m_pc, m_opnd, m_sela, m_selb, m_op, 0, 0, 0, 0), 1'b1);
      m_opnd = w[10:0];
      push(vec(m_pc, m_opnd, m_sela, m_selb, m_op, 0,
               (opc == T_LD || opc == T_ADD || opc == T_SUB), (opc == T_STO), 0),
           1'($urandom_range(0, 1)));
      if (opc == T_HLT) begin
         m_halted = 1'b1;
         m_count  = m_count + 1;
         return;
      end
      wa = 1'b1;
      case (opc)
         T_LD:    m_sela = 2'd0;
         T_LDI:   m_sela = 2'd1;
         T_ADD:   begin m_sela = 2'd2; m_selb = 1'b0; m_op = 1'b0; end
         T_ADDI:  begin m_sela = 2'd2; m_selb = 1'b1; m_op = 1'b0; end
         T_SUB:   begin m_sela = 2'd2; m_selb = 1'b0; m_op = 1'b1; end
         T_SUBI:  begin m_sela = 2'd2; m_selb = 1'b1; m_op = 1'b1; end
         default: wa = 1'b0;
      endcase
      push(vec(m_pc, m_opnd, m_sela, m_selb, m_op, wa, 0, 0, 0), 1'($urandom_range(0, 1)));
      m_pc    = m_pc + 1;
      m_count = m_count + 1;
   endtask

   task automatic drive(input int n);
      for (int i = 0; i < n; i++) begin
         got_q.push_back(pack_dut());
         bus.Run = run_q.pop_front();
         @(negedge Clock);
      end
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 2048; i++) rom[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
   endtask

   task automatic do_reset();
      Reset   = 1'b1;
      bus.Run = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      logic [W-1:0] g, e;
      model_reset();
      Reset   = 1'b1;
      bus.Run = 1'b1;
      @(negedge Clock);
      @(negedge Clock);
      g = pack_dut();
      e = vec(11'd0, 11'd0, 2'd0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL reset_values: got %h expected %h", g, e); end
      n_cmp++;
      if (bus.Halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b expected 0", bus.Halted); end
   endtask

   task automatic test_ldi();
      logic [W-1:0] g, e;
      int c = 0;
      fill_nop(); do_reset();
      rom[0] = 16'h1805;
      model_instr(); model_idle(1);
      drive(run_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL ldi cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
   endtask

   task automatic test_ld_add_sub();
      logic [W-1:0] g, e;
      int c = 0;
      fill_nop(); do_reset();
      rom[0] = 16'h1003; rom[1] = 16'h2004; rom[2] = 16'h3802;
      repeat (3) model_instr();
      model_idle(1);
      drive(run_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL ld_add_subi cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
   endtask

   task automatic test_store();
      logic [W-1:0] g, e;
      int c = 0;
      fill_nop(); do_reset();
      rom[0] = 16'h0807;
      model_instr(); model_idle(2);
      drive(run_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL store cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
   endtask

   task automatic test_run_low();
      logic [W-1:0] g, e;
      int c = 0;
      fill_nop(); do_reset();
      rom[0] = 16'h1809; rom[1] = 16'h2801;
      model_idle(10); model_instr(); model_idle(10); model_instr(); model_idle(1);
      drive(run_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL run_low cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
   endtask

   task automatic test_halt();
      logic [W-1:0] g, e;
      int c = 0;
      fill_nop(); do_reset();
      rom[0] = 16'h2803; rom[1] = 16'h1009; rom[2] = 16'h0000;
      repeat (3) model_instr();
      model_halt(50);
      drive(run_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL halt cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [W-1:0] g, e;
      int c = 0;
      fill_nop(); do_reset();
      rom[0] = 16'h1805; rom[1] = 16'h2004;
      repeat (2) model_instr();
      drive(run_q.size() - 1);
      got_q.push_back(pack_dut());
      run_q.delete();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL pre_abort cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
      #2 Reset = 1'b1;
      bus.Run = 1'b0;
      #1;
      n_cmp++;
      if (bus.WrAcc !== 1'b0) begin n_bad++; $display("FAIL abort_wracc: got %b expected 0", bus.WrAcc); end
      n_cmp++;
      if (bus.PcAddr !== 11'd0) begin n_bad++; $display("FAIL abort_pc: got %h expected 000", bus.PcAddr); end
      n_cmp++;
      if ({bus.RdRam, bus.WrRam} !== 2'b00) begin
         n_bad++; $display("FAIL abort_ram: got %b expected 00", {bus.RdRam, bus.WrRam});
      end
      @(negedge Clock);
      Reset = 1'b0;
      model_reset();
      model_instr(); model_idle(1);
      drive(run_q.size());
      c = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL post_abort cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] g, e;
      int c = 0;
      int k;
      fill_nop(); do_reset();
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(1, 10);
         rom[i] = {(k <= 7) ? 5'(k) : 5'($urandom_range(8, 31)), 11'($urandom)};
      end
      rom[40] = {T_HLT, 11'($urandom)};
      for (int i = 0; i < 41; i++) begin
         model_idle($urandom_range(0, 2));
         model_instr();
      end
      model_halt(20);
      drive(run_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL random cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
   endtask

   task automatic test_pc_wrap();
      logic [W-1:0] g, e;
      int c = 0;
      fill_nop(); do_reset();
      repeat (2048) model_instr();
      model_idle(1);
      drive(run_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL pc_wrap cycle %0d: got %h expected %h", c, g, e); end
         c++;
      end
      n_cmp++;
      if (bus.PcAddr !== 11'h000) begin n_bad++; $display("FAIL pc_wrap_final: got %h expected 000", bus.PcAddr); end
`ifdef BIP_CTRL_INSTR_COUNT_EN
      n_cmp++;
      if (bus.InstrCount !== 16'd2048) begin
         n_bad++; $display("FAIL instr_count: got %0d expected 2048", bus.InstrCount);
      end
`endif
   endtask

   initial begin
      bus.Run = 1'b0;
      for (int i = 0; i < 2048; i++) rom[i] = 16'h4000;
      test_reset();
      test_ldi();
      test_ld_add_sub();
      test_store();
      test_run_low();
      test_halt();
      test_reset_mid_exec();
      test_random();
      test_pc_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
